// File: rtl/road_pkg.sv
// Shared road constants and sequencer state type for the scheduler,
// edge store and collision checker.
package road_pkg;
  localparam int DELTA_W = 8;

  localparam logic [9:0] XCENTER   = 10'd464;
  localparam logic [9:0] HALF_ROAD = 10'd35;
  localparam logic [9:0] X_MIN     = 10'd184;
  localparam logic [9:0] X_MAX     = 10'd743;

  localparam logic [3:0]  SCRIPT_LEN  = 4'd9;
  localparam logic [15:0] LEVEL_ROWS  = 16'd114;
  localparam logic [3:0]  MAX_LEVEL   = 4'd8;
  localparam logic [DELTA_W-1:0] LEVEL_GAIN = 8'd8;
  localparam logic [8:0]  CRASH_LINES = 9'd480;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_RUN,
    ST_CRASH
  } state_e;
endpackage

// File: rtl/road_delta_scale.sv
// Sign-aware difficulty scaling: pushes a non-zero bend slope away from
// zero by level*LEVEL_GAIN, leaving a straight entry straight.
module road_delta_scale
  import road_pkg::*;
(
  input  logic [4:0]                script_delta,
  input  logic [3:0]                level,
  output logic signed [DELTA_W-1:0] delta_s
);
  logic signed [DELTA_W-1:0] base;
  logic signed [DELTA_W-1:0] gain;

  always_comb begin
    base = {{(DELTA_W-5){script_delta[4]}}, script_delta};
    gain = {{(DELTA_W-4){1'b0}}, level} * LEVEL_GAIN;
    if (script_delta == 5'd0)
      delta_s = '0;
    else if (script_delta[4])
      delta_s = base - gain;
    else
      delta_s = base + gain;
  end
endmodule

// File: rtl/road_scheduler.sv
// Scan-line road sequencer: fetches bend entries from the script ROM,
// integrates the road centre and runs the idle/play/pause/crash flow.
module road_scheduler
  import road_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_tick,
  input  logic        run,
  input  logic        crash,
  output logic [3:0]  script_addr,
  input  logic [4:0]  script_delta,
  input  logic [8:0]  script_rows,
  output logic        edge_valid,
  output logic [9:0]  left_edge,
  output logic [9:0]  right_edge,
  output logic [3:0]  level,
  output logic [15:0] distance,
  output logic        crashing,
  output logic [2:0]  state_dbg
);
  localparam logic signed [10:0] MAX_S = {1'b0, X_MAX};
  localparam logic signed [10:0] MIN_S = {1'b0, X_MIN};

  state_e                    state;
  logic [9:0]                centre;
  logic signed [DELTA_W-1:0] delta_s;
  logic signed [DELTA_W-1:0] delta_new;
  logic [8:0]                rows_left;
  logic                      tick_pend;
  logic [8:0]                crash_cnt;
  logic signed [10:0]        centre_sum;

  road_delta_scale u_scale (
    .script_delta (script_delta),
    .level        (level),
    .delta_s      (delta_new)
  );

  assign centre_sum = $signed({1'b0, centre}) + {{(11-DELTA_W){delta_s[DELTA_W-1]}}, delta_s};
  assign left_edge  = centre - HALF_ROAD;
  assign right_edge = centre + HALF_ROAD;
  assign state_dbg  = state;

  // edge_valid is a one-cycle strobe with no back-pressure: left/right_edge
  // hold the new row-0 pair in the same cycle and the consumer must take it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      centre      <= XCENTER;
      delta_s     <= '0;
      rows_left   <= '0;
      tick_pend   <= 1'b0;
      crash_cnt   <= '0;
      edge_valid  <= 1'b0;
      level       <= 4'd1;
      distance    <= '0;
      script_addr <= '0;
      crashing    <= 1'b0;
    end else begin
      edge_valid <= 1'b0;
      if (crash) begin
        // Crash wins over a same-cycle tick; that line is dropped.
        state     <= ST_CRASH;
        crashing  <= 1'b1;
        centre    <= XCENTER;
        crash_cnt <= CRASH_LINES;
        tick_pend <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (line_tick) edge_valid <= 1'b1;
            if (run) state <= ST_FETCH;
          end
          ST_FETCH: begin
            if (run) begin
              if (line_tick) tick_pend <= 1'b1;
              state <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (run) begin
              if (line_tick) tick_pend <= 1'b1;
              delta_s     <= delta_new;
              rows_left   <= (script_rows == 9'd0) ? 9'd1 : script_rows;
              script_addr <= (script_addr == SCRIPT_LEN - 4'd1) ? 4'd0 : script_addr + 4'd1;
              state       <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (run && (line_tick || tick_pend)) begin
              // A tick colliding with a pending one stays pending.
              tick_pend  <= tick_pend && line_tick;
              edge_valid <= 1'b1;
              if (centre_sum > MAX_S) begin
                centre  <= X_MAX;
                delta_s <= -delta_s;
              end else if (centre_sum < MIN_S) begin
                centre  <= X_MIN;
                delta_s <= -delta_s;
              end else begin
                centre <= centre_sum[9:0];
              end
              if (distance == LEVEL_ROWS - 16'd1) begin
                distance <= '0;
                if (level != MAX_LEVEL) level <= level + 4'd1;
              end else begin
                distance <= distance + 16'd1;
              end
              rows_left <= rows_left - 9'd1;
              if (rows_left == 9'd1) state <= ST_FETCH;
            end
          end
          ST_CRASH: begin
            if (line_tick) begin
              edge_valid <= 1'b1;
              if (crash_cnt == 9'd1) begin
                state       <= ST_IDLE;
                crashing    <= 1'b0;
                crash_cnt   <= '0;
                level       <= 4'd1;
                distance    <= '0;
                script_addr <= '0;
                delta_s     <= '0;
                rows_left   <= '0;
              end else begin
                crash_cnt <= crash_cnt - 9'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_road_scheduler.sv
// Randomized bench for road_scheduler: a line-level game model predicts each
// edge pair into a queue and a monitor compares on every edge_valid strobe.
module tb_road_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_tick;
  logic        run;
  logic        crash;
  logic [3:0]  script_addr;
  logic [4:0]  script_delta;
  logic [8:0]  script_rows;
  logic        edge_valid;
  logic [9:0]  left_edge;
  logic [9:0]  right_edge;
  logic [3:0]  level;
  logic [15:0] distance;
  logic        crashing;
  logic [2:0]  state_dbg;

  road_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_tick    (line_tick),
    .run          (run),
    .crash        (crash),
    .script_addr  (script_addr),
    .script_delta (script_delta),
    .script_rows  (script_rows),
    .edge_valid   (edge_valid),
    .left_edge    (left_edge),
    .right_edge   (right_edge),
    .level        (level),
    .distance     (distance),
    .crashing     (crashing),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / ROM ----------------
  always #5 clk = ~clk;

  logic signed [4:0] rom_delta [9];
  logic [8:0]        rom_rows  [9];

  always @(posedge clk) begin
    script_delta <= rom_delta[script_addr];
    script_rows  <= rom_rows[script_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [19:0] exp_q[$];
  int n_tests  = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_edges  = 0;

  // Line-level game model: 0 idle, 1 play, 2 crash flush.
  int m_mode, m_centre, m_delta, m_rows, m_entry, m_level, m_dist, m_crash_left;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_edge(input int c);
    logic [9:0] l, r;
    l = 10'(c - 35);
    r = 10'(c + 35);
    exp_q.push_back({l, r});
    n_pushed++;
  endtask

  task automatic model_reset();
    m_mode = 0; m_centre = 464; m_delta = 0; m_rows = 0; m_entry = 0;
    m_level = 1; m_dist = 0; m_crash_left = 0;
  endtask

  task automatic model_crash();
    m_mode = 2;
    m_centre = 464;
    m_crash_left = 480;
  endtask

  task automatic model_line();
    int d, nc;
    if (m_mode == 2) begin
      push_edge(464);
      m_crash_left--;
      if (m_crash_left == 0) begin
        m_mode = 1; m_level = 1; m_dist = 0; m_entry = 0; m_rows = 0; m_delta = 0;
      end
    end else if (m_mode == 0) begin
      push_edge(464);
    end else begin
      if (m_rows == 0) begin
        d = rom_delta[m_entry];
        if (d > 0)      m_delta = d + m_level * 8;
        else if (d < 0) m_delta = d - m_level * 8;
        else            m_delta = 0;
        m_rows  = (rom_rows[m_entry] == 0) ? 1 : int'(rom_rows[m_entry]);
        m_entry = (m_entry + 1) % 9;
      end
      nc = m_centre + m_delta;
      if (nc > 743) begin
        nc = 743; m_delta = -m_delta;
      end else if (nc < 184) begin
        nc = 184; m_delta = -m_delta;
      end
      m_centre = nc;
      push_edge(nc);
      if (m_dist == 113) begin
        m_dist = 0;
        if (m_level < 8) m_level++;
      end else begin
        m_dist++;
      end
      m_rows--;
    end
  endtask

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic issue_tick();
    line_tick = 1'b1;
    if (m_mode != 1 || run) model_line();
    @(negedge clk);
    line_tick = 1'b0;
  endtask

  task automatic pause_window();
    repeat (4) @(negedge clk);
    run = 1'b0;
    check("pause_distance", int'(distance), m_dist);
    check("pause_level", int'(level), m_level);
    repeat (5) begin
      repeat (2) @(negedge clk);
      issue_tick();
    end
    check("paused_distance_frozen", int'(distance), m_dist);
    run = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic play_ticks(input int n);
    int gap;
    bit quick_ok;
    quick_ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      // Right after an entry ends, sometimes land the next tick in FETCH/LOAD.
      if (m_rows == 0 && quick_ok && $urandom_range(0, 1) == 1) begin
        gap = $urandom_range(1, 2);
        quick_ok = 1'b0;
      end else begin
        gap = $urandom_range(3, 6);
        quick_ok = 1'b1;
      end
      repeat (gap - 1) @(negedge clk);
      issue_tick();
      if (i % 200 == 100) begin
        pause_window();
        quick_ok = 1'b0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_edge_valid"}, int'(edge_valid), 0);
    check({tag, "_left_edge"}, int'(left_edge), 429);
    check({tag, "_right_edge"}, int'(right_edge), 499);
    check({tag, "_level"}, int'(level), 1);
    check({tag, "_distance"}, int'(distance), 0);
    check({tag, "_script_addr"}, int'(script_addr), 0);
    check({tag, "_crashing"}, int'(crashing), 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && edge_valid === 1'b1) begin
        n_edges++;
        if (exp_q.size() == 0) begin
          check("unexpected_edge_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("edge_left", int'(left_edge), int'(e[19:10]));
          check("edge_right", int'(right_edge), int'(e[9:0]));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget, got %0t expected below 2000000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; line_tick = 1'b0; run = 1'b0; crash = 1'b0;
    rom_delta[0] = 5'sd0;   rom_rows[0] = 9'd10;
    rom_delta[1] = 5'sd5;   rom_rows[1] = 9'd18;
    rom_delta[2] = 5'sd15;  rom_rows[2] = 9'd40;
    rom_delta[3] = -5'sd5;  rom_rows[3] = 9'd12;
    for (int i = 4; i < 8; i++) begin
      rom_delta[i] = 5'($urandom_range(0, 31));
      rom_rows[i]  = 9'($urandom_range(4, 25));
    end
    rom_delta[8] = 5'($urandom_range(0, 31));
    rom_rows[8]  = 9'd0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Idle: straight edges while not running.
    repeat (2) begin
      repeat (3) @(negedge clk);
      issue_tick();
    end

    // Play through level-ups to saturation, with pauses and pended ticks.
    run = 1'b1;
    m_mode = 1;
    repeat (3) @(negedge clk);
    play_ticks(1100);
    repeat (6) @(negedge clk);
    check("level_saturated", int'(level), m_level);
    check("distance_after_play", int'(distance), m_dist);

    // Crash together with a tick, then a re-crash mid-flush.
    crash = 1'b1; line_tick = 1'b1;
    model_crash();
    @(negedge clk);
    crash = 1'b0; line_tick = 1'b0;
    check("crash_no_edge", int'(edge_valid), 0);
    check("crashing_high", int'(crashing), 1);
    repeat (100) begin
      @(negedge clk);
      issue_tick();
    end
    crash = 1'b1;
    model_crash();
    @(negedge clk);
    crash = 1'b0;
    repeat (480) begin
      @(negedge clk);
      issue_tick();
    end
    check("post_crash_level", int'(level), m_level);
    check("post_crash_distance", int'(distance), m_dist);
    check("post_crash_addr", int'(script_addr), 0);
    check("post_crash_crashing", int'(crashing), 0);

    repeat (3) @(negedge clk);
    play_ticks(60);

    // Asynchronous reset mid-run.
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    model_reset();
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue_tick();

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("edge_count", n_edges, n_pushed);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
